// File: rtl/tms_display_capture.sv
`timescale 1ns/1ps
// Purpose: snoop TMS1x00 R/O outputs, capture each settled digit into a 16x8 frame buffer, Wishbone slave.
// Latency: capture lands SETTLE_CYCLES+2 clocks after an R/O edge from IDLE; Wishbone ack one clock after acceptance.
// Backpressure: none on the core side (pure snooper); Wishbone accepts one transfer, then idles while ack is high.
//
// Ports:
//   wb_clk_i, rst_n          sole clock, asynchronous active-low reset
//   R_in[15:0], O_in[7:0]    digit strobes / segment data from the core
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_dat_o, wbs_ack_o
//                            Wishbone slave, selected by wbs_adr_i[22]; [6] region, [5:2] index
//   irq_o                    sticky frame-done interrupt, only when TMS_CAPTURE_IRQ_EN is defined
//
// Status word (status region, index 0):
//   [31:16] frame_cnt (zero-extended / truncated to 16 bits)
//   [15:8]  err_cnt
//   [7]     irq_o
//   [6:5]   FSM state (0 IDLE, 1 SETTLE, 2 CAPT)
//   [4]     0
//   [3:0]   last_idx
// The published field list adds up to 34 bits. Dropping its two-bit pad is the only
// way to fit it into 32, so the irq bit sits directly above the state field.
// Status write: bit0 clears frame_cnt/err_cnt, bit1 clears irq_o.
//
// Build option: TMS_CAPTURE_IRQ_EN enables the irq_o logic. When it is undefined,
// irq_o is tied low.

module tms_display_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic [15:0] R_in,
    input  logic [7:0]  O_in,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o
);

    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CAPT   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      r_q, r_prev, r_cap;
    logic [7:0]       o_q, o_cap;
    logic [7:0]       cnt, cnt_nxt;
    logic [3:0]       idx, last_idx;
    logic [7:0]       frame [16];
    logic [CNT_W-1:0] frame_cnt;
    logic [7:0]       err_cnt;

    logic             r_onehot, r_multi, err_evt;
    logic [3:0]       r_log2;
    logic             enter_settle, cap_en, wrap;

    logic             wb_valid, wb_acc, stat_sel, clr_cnt, clr_irq;
    logic [31:0]      rd_dat, status;
    logic [15:0]      fc16;

    // ---------------- strobe decode on the registered inputs ----------------
    assign r_onehot = (r_q != 16'h0) && ((r_q & (r_q - 16'd1)) == 16'h0);
    assign r_multi  = (r_q != 16'h0) && !r_onehot;
    // A malformed strobe is counted once, on the cycle it appears, whatever
    // state the FSM is in; otherwise a bad strobe arriving straight out of
    // CAPT or SETTLE would go unnoticed.
    assign err_evt  = r_multi && (r_q != r_prev);

    always_comb begin
        r_log2 = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_q[i]) r_log2 = 4'(i);
        end
    end

    // ---------------- capture FSM ----------------
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        enter_settle = 1'b0;
        cap_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (r_onehot) begin
                    state_nxt    = ST_SETTLE;
                    enter_settle = 1'b1;
                    cnt_nxt      = 8'd1;
                end
            end
            ST_SETTLE: begin
                // r_cap/o_cap hold the values seen on entry, so any wiggle
                // since then aborts the attempt without writing.
                if ((r_q != r_cap) || (o_q != o_cap)) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == SETTLE_N) begin
                    cap_en    = 1'b1;
                    state_nxt = ST_CAPT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_CAPT: begin
                if (r_q != r_cap) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A capture at or below the previous digit index means the scan restarted.
    assign wrap = cap_en && (idx <= last_idx);

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= 16'h0;
            o_q      <= 8'h0;
            r_prev   <= 16'h0;
            r_cap    <= 16'h0;
            o_cap    <= 8'h0;
            idx      <= 4'h0;
            last_idx <= 4'hF;
            cnt      <= 8'h0;
            state    <= ST_IDLE;
            for (int i = 0; i < 16; i++) frame[i] <= 8'h00;
        end else begin
            r_q    <= R_in;
            o_q    <= O_in;
            r_prev <= r_q;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            if (enter_settle) begin
                r_cap <= r_q;
                o_cap <= o_q;
                idx   <= r_log2;
            end
            if (cap_en) begin
                frame[idx] <= o_q;
                last_idx   <= idx;
            end
        end
    end

    // ---------------- counters (clear beats increment) ----------------
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= 8'h0;
        end else begin
            if (clr_cnt)   frame_cnt <= '0;
            else if (wrap) frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

            if (clr_cnt)                           err_cnt <= 8'h0;
            else if (err_evt && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
        end
    end

    // ---------------- interrupt ----------------
`ifdef TMS_CAPTURE_IRQ_EN
    logic irq_q;
    // A wrap in the same cycle as a clear re-arms the flag, so no frame is lost.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)       irq_q <= 1'b0;
        else if (wrap)    irq_q <= 1'b1;
        else if (clr_irq) irq_q <= 1'b0;
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
    logic unused_irq;
    assign unused_irq = clr_irq;
`endif

    // ---------------- Wishbone slave ----------------
    assign wb_valid = wbs_cyc_i && wbs_stb_i && wbs_adr_i[22];
    // No acceptance while ack is high; a held strobe therefore alternates
    // accept / ack, one ack per transfer.
    assign wb_acc   = wb_valid && !wbs_ack_o;
    assign stat_sel = wbs_adr_i[6] && (wbs_adr_i[5:2] == 4'h0);
    assign clr_cnt  = wb_acc && wbs_we_i && stat_sel && wbs_dat_i[0];
    assign clr_irq  = wb_acc && wbs_we_i && stat_sel && wbs_dat_i[1];

    assign fc16   = 16'(frame_cnt);
    assign status = {fc16, err_cnt, irq_o, 2'(state), 1'b0, last_idx};

    always_comb begin
        rd_dat = 32'h0;
        if (!wbs_adr_i[6])  rd_dat = {24'h0, frame[wbs_adr_i[5:2]]};
        else if (stat_sel)  rd_dat = status;
    end

    // Read data samples the buffer before this edge's capture lands, so a
    // same-cycle read of the entry being written returns the old value.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= wb_acc;
            if (wb_acc && !wbs_we_i) wbs_dat_o <= rd_dat;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:23], wbs_adr_i[21:7], wbs_adr_i[1:0], wbs_dat_i[31:2]};

endmodule

// File: tb/tb_tms_display_capture.sv
`timescale 1ns/1ps
module tb_tms_display_capture;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic [15:0] R_in;
    logic [7:0]  O_in;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] STAT = 32'h0040_0040;
`ifdef TMS_CAPTURE_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    tms_display_capture #(.SETTLE_CYCLES(4), .CNT_W(16)) dut (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .R_in     (R_in),
        .O_in     (O_in),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o),
        .irq_o    (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } wb_vec_t;

    wb_vec_t rst_tab  [17];
    wb_vec_t scan_tab [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives at the next negedge, so acceptance happens on the following posedge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
        bit got = 1'b0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wd;
        for (int n = 0; n < 16; n++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin got = 1'b1; break; end
        end
        rd = wbs_dat_o;
        if (!got) begin
            checks++; errors++;
            $display("FAIL wb_timeout: got no ack expected ack at adr %h", adr);
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic rd_stat(output logic [31:0] s);
        wb_xfer(1'b0, STAT, 32'h0, s);
    endtask

    task automatic digit(input logic [15:0] r, input logic [7:0] o, input int clks);
        @(negedge wb_clk_i);
        R_in = r; O_in = o;
        repeat (clks) @(posedge wb_clk_i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, st;
        logic [3:0]  ackv;

        for (int i = 0; i < 16; i++) begin
            rst_tab[i]  = '{1'b0, BASE | (32'(i) << 2), 32'h0, 32'h0};
            scan_tab[i] = '{1'b0, BASE | (32'(i) << 2), 32'h0, 32'(i)};
        end
        rst_tab[16]  = '{1'b0, STAT, 32'h0, 32'h0000_000F};
        // Scan after reset: idx0 wraps against last_idx=F, idx1..15 do not,
        // the closing idx0 wraps again -> frame_cnt=2, last_idx=0, state IDLE.
        scan_tab[16] = '{1'b0, STAT, 32'h0, 32'h0002_0000 | (32'(IRQ) << 7)};

        R_in = 16'h0; O_in = 8'h0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        @(negedge wb_clk_i); rst_n = 1'b1;

        // ---- reset readback ----
        for (int i = 0; i < 17; i++) begin
            wb_xfer(rst_tab[i].we, rst_tab[i].adr, rst_tab[i].wdat, rd);
            chk($sformatf("rst_rd%0d", i), rd, rst_tab[i].exp);
        end

        // ---- held strobe: ack pattern 1,0,1,0 ----
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE;
        for (int k = 0; k < 4; k++) begin
            @(posedge wb_clk_i); #1;
            ackv[k] = wbs_ack_o;
        end
        chk("ack_pattern", {28'h0, ackv}, 32'h0000_0005);
        // unselected address (bit22 clear) is never acked
        @(negedge wb_clk_i);
        wbs_adr_i = 32'h0000_0040;
        ackv = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge wb_clk_i); #1;
            ackv[k] = wbs_ack_o;
        end
        // first sample may still be the trailing ack of the held transfer
        chk("ack_unselected", {29'h0, ackv[3:1]}, 32'h0);
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        repeat (2) @(posedge wb_clk_i);

        // ---- capture latency: write lands on clock 6 ----
        digit(16'h0004, 8'hA5, 5);
        wb_xfer(1'b0, BASE | 32'h8, 32'h0, rd);    // accepted on clock 6
        chk("lat_clk6_old", rd, 32'h0);
        wb_xfer(1'b0, BASE | 32'h8, 32'h0, rd);
        chk("lat_frame2", rd, 32'h0000_00A5);
        digit(16'h0000, 8'h00, 4);
        digit(16'h0008, 8'h5A, 6);
        wb_xfer(1'b0, BASE | 32'hC, 32'h0, rd);    // accepted on clock 7
        chk("lat_clk7_new", rd, 32'h0000_005A);
        rd_stat(st);
        chk("stat_capt", st, 32'h0001_0043 | (32'(IRQ) << 7));
        digit(16'h0000, 8'h00, 4);
        rd_stat(st);
        chk("stat_idle", (st >> 5) & 32'h3, 32'h0);

        // ---- full scan from a fresh reset ----
        @(negedge wb_clk_i); rst_n = 1'b0;
        @(negedge wb_clk_i); rst_n = 1'b1;
        for (int k = 0; k < 17; k++) digit(16'h1 << (k % 16), 8'(k % 16), 8);
        digit(16'h0000, 8'h00, 4);
        for (int i = 0; i < 17; i++) begin
            wb_xfer(scan_tab[i].we, scan_tab[i].adr, scan_tab[i].wdat, rd);
            chk($sformatf("scan_rd%0d", i), rd, scan_tab[i].exp);
        end
        #1;
        chk("irq_after_scan", {31'h0, irq_o}, {31'h0, IRQ});
        wb_xfer(1'b1, STAT, 32'h2, rd);
        #1;
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);
        rd_stat(st);
        chk("stat_after_irqclr", st, 32'h0002_0000);
        wb_xfer(1'b1, STAT, 32'h1, rd);
        rd_stat(st);
        chk("cnt_cleared", st >> 16, 32'h0);

        // ---- malformed strobes ----
        @(negedge wb_clk_i); R_in = 16'h0003;
        @(negedge wb_clk_i); R_in = 16'h0000;
        repeat (3) @(posedge wb_clk_i);
        rd_stat(st);
        chk("err_one", (st >> 8) & 32'hFF, 32'h1);
        wb_xfer(1'b0, BASE | 32'h0, 32'h0, rd);
        chk("err_nowrite0", rd, 32'h0);
        wb_xfer(1'b0, BASE | 32'h4, 32'h0, rd);
        chk("err_nowrite1", rd, 32'h1);
        for (int p = 0; p < 299; p++) begin
            @(negedge wb_clk_i); R_in = 16'h0003;
            @(negedge wb_clk_i); R_in = 16'h0000;
        end
        repeat (3) @(posedge wb_clk_i);
        rd_stat(st);
        chk("err_saturate", (st >> 8) & 32'hFF, 32'hFF);
        wb_xfer(1'b1, STAT, 32'h1, rd);
        rd_stat(st);
        chk("err_cleared", (st >> 8) & 32'hFF, 32'h0);

        // ---- unstable O blocks capture, steady O captures ----
        digit(16'h0020, 8'h50, 0);
        for (int j = 1; j <= 10; j++) begin
            repeat (2) @(negedge wb_clk_i);
            O_in = 8'(8'h50 + j);
        end
        wb_xfer(1'b0, BASE | 32'h14, 32'h0, rd);
        chk("unstable_nocap", rd, 32'h05);
        repeat (10) @(posedge wb_clk_i);
        wb_xfer(1'b0, BASE | 32'h14, 32'h0, rd);
        chk("steady_cap", rd, 32'h5A);
        digit(16'h0000, 8'h00, 4);

        // ---- reset mid-capture: no write survives ----
        digit(16'h0080, 8'hEE, 3);
        @(negedge wb_clk_i); rst_n = 1'b0; R_in = 16'h0;
        @(negedge wb_clk_i); rst_n = 1'b1;
        repeat (8) @(posedge wb_clk_i);
        wb_xfer(1'b0, BASE | 32'h1C, 32'h0, rd);
        chk("rst_midcap", rd, 32'h0);

        // ---- reset mid bus cycle drops ack ----
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = STAT;
        @(posedge wb_clk_i); #1;
        chk("ack_before_rst", {31'h0, wbs_ack_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ack_dropped", {31'h0, wbs_ack_o}, 32'h0);
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0; rst_n = 1'b1;
        repeat (2) @(posedge wb_clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
